// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiplier controller.
// Holds the FSM state encoding, default operand width and qpair codes.
package booth_pkg;

  localparam int N_BITS_DEF = 4;

  localparam logic [1:0] QP_SUB = 2'b10;
  localparam logic [1:0] QP_ADD = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_OP    = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/booth_cnt.sv
// Loadable iteration down-counter with zero/one flags.
// Decrement saturates at zero so the count can never wrap.
module booth_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o,
  output logic         one_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
  assign one_o  = (cnt_q == W'(1));

endmodule

// File: rtl/booth_ctrl.sv
// Control FSM sequencing a radix-2 Booth multiplier datapath (A, Q, M).
// Build option BOOTH_SKIP_EN: shift directly from OP when qpair is 00/11.
//
// state | meaning
// IDLE  | waiting for start, all controls low
// LOAD  | load M and Q, clear A and Q-1, preset iteration count
// OP    | add/subtract M into A depending on qpair
// SHIFT | arithmetic shift of A:Q:Q-1, count one iteration
// DONE  | one-cycle done pulse, product in A:Q
module booth_ctrl
  import booth_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] qpair,
  output logic       CargaM,
  output logic       CargaQ,
  output logic       ResetA,
  output logic       CargaA,
  output logic       SumaResta,
  output logic       DesplazaA,
  output logic       DesplazaQ,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(N_BITS + 1);

  state_e state_q, state_d;
  logic   cnt_load, cnt_dec, cnt_zero, cnt_one;

  booth_cnt #(.W(CW)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (CW'(N_BITS)),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero),
    .one_o      (cnt_one)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    CargaM    = 1'b0;
    CargaQ    = 1'b0;
    ResetA    = 1'b0;
    CargaA    = 1'b0;
    SumaResta = 1'b0;
    DesplazaA = 1'b0;
    DesplazaQ = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        CargaM   = 1'b1;
        CargaQ   = 1'b1;
        ResetA   = 1'b1;
        busy     = 1'b1;
        cnt_load = 1'b1;
        state_d  = S_OP;
      end
      S_OP: begin
        busy = 1'b1;
        if (qpair == QP_SUB) begin
          CargaA    = 1'b1;
          SumaResta = 1'b1;
          state_d   = S_SHIFT;
        end else if (qpair == QP_ADD) begin
          CargaA  = 1'b1;
          state_d = S_SHIFT;
        end else begin
`ifdef BOOTH_SKIP_EN
          // nothing to add: shift in place and count the iteration here
          DesplazaA = 1'b1;
          DesplazaQ = 1'b1;
          cnt_dec   = 1'b1;
          state_d   = (cnt_one || cnt_zero) ? S_DONE : S_OP;
`else
          state_d = S_SHIFT;
`endif
        end
      end
      S_SHIFT: begin
        busy      = 1'b1;
        DesplazaA = 1'b1;
        DesplazaQ = 1'b1;
        cnt_dec   = 1'b1;
        state_d   = (cnt_one || cnt_zero) ? S_DONE : S_OP;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
